// File: rtl/hazard_unit.sv
// Decode-stage interlock: load-use and FPU RAW/WAW/structural stalls, branch flush,
// and the occupancy FSM for the single non-pipelined multi-cycle FPU.
module hazard_unit #(
    parameter int unsigned FPU_LAT = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_id,
    input  logic [3:0]  Y_id,
    input  logic [3:0]  X_id,
    input  logic        use_y_id,
    input  logic        use_x_id,
    input  logic        src_fp_id,
    input  logic [3:0]  Z_id,
    input  logic [2:0]  RW_id,
    input  logic        fpu_id,
    input  logic [3:0]  Z_ex,
    input  logic [2:0]  RW_ex,
    input  logic        mem_rd_ex,
    input  logic        branch_taken_ex,
    input  logic        fpu_wb_gnt,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        fpu_issue,
    output logic        fpu_busy,
    output logic        fpu_wb_req,
    output logic [3:0]  fpu_wb_z,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {StIdle, StBusy, StWb} fpu_state_e;

    fpu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       fz_q, fz_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic fpu_haz;

    // Only the integer write of EX and the F write of ID matter for hazards.
    logic unused_rw;
    assign unused_rw = ^{RW_id[1:0], RW_ex[2], RW_ex[0]};

    always_comb begin
        fpu_busy   = (state_q != StIdle);
        fpu_wb_req = (state_q == StWb);
        fpu_wb_z   = fpu_busy ? fz_q : 4'd0;

        load_use = valid_id & mem_rd_ex & RW_ex[1] & ~src_fp_id &
                   ((use_y_id & (Y_id == Z_ex)) | (use_x_id & (X_id == Z_ex)));
        fpu_haz  = valid_id & fpu_busy &
                   (fpu_id |
                    (src_fp_id & ((use_y_id & (Y_id == fz_q)) | (use_x_id & (X_id == fz_q)))) |
                    (RW_id[2] & (Z_id == fz_q)));

        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (branch_taken_ex) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (load_use | fpu_haz) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end

        fpu_issue = valid_id & fpu_id & ~fpu_busy & ~branch_taken_ex & ~load_use;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fz_d    = fz_q;
        unique case (state_q)
            StIdle: begin
                if (fpu_issue) begin
                    state_d = StBusy;
                    fz_d    = Z_id;
                    cnt_d   = CNT_W'(FPU_LAT - 1);
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                if (fpu_wb_gnt) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_id && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            fz_q        <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fz_q        <= fz_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit with FPU_LAT=4; expected values are hand-derived.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_id, use_y_id, use_x_id, src_fp_id, fpu_id;
    logic [3:0]  Y_id, X_id, Z_id, Z_ex;
    logic [2:0]  RW_id, RW_ex;
    logic        mem_rd_ex, branch_taken_ex, fpu_wb_gnt;
    logic        stall_if, stall_id, bubble_ex, flush_id;
    logic        fpu_issue, fpu_busy, fpu_wb_req;
    logic [3:0]  fpu_wb_z;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_unit #(.FPU_LAT(4), .CNT_W(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_id        (valid_id),
        .Y_id            (Y_id),
        .X_id            (X_id),
        .use_y_id        (use_y_id),
        .use_x_id        (use_x_id),
        .src_fp_id       (src_fp_id),
        .Z_id            (Z_id),
        .RW_id           (RW_id),
        .fpu_id          (fpu_id),
        .Z_ex            (Z_ex),
        .RW_ex           (RW_ex),
        .mem_rd_ex       (mem_rd_ex),
        .branch_taken_ex (branch_taken_ex),
        .fpu_wb_gnt      (fpu_wb_gnt),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .flush_id        (flush_id),
        .fpu_issue       (fpu_issue),
        .fpu_busy        (fpu_busy),
        .fpu_wb_req      (fpu_wb_req),
        .fpu_wb_z        (fpu_wb_z),
        .stall_cnt       (stall_cnt)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_id = 0; Y_id = 0; X_id = 0; use_y_id = 0; use_x_id = 0; src_fp_id = 0;
        Z_id = 0; RW_id = 0; fpu_id = 0; Z_ex = 0; RW_ex = 0; mem_rd_ex = 0;
        branch_taken_ex = 0;
    endtask

    task automatic set_load_use();
        mem_rd_ex = 1; RW_ex = 3'b010; Z_ex = 4'd3;
        valid_id = 1; Y_id = 4'd3; use_y_id = 1; src_fp_id = 0;
    endtask

    task automatic drain();
        bit done = 0;
        clear_inputs();
        fpu_wb_gnt = 1;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (!fpu_busy) done = 1;
            else tick();
        end
        check("drain_idle", {15'd0, done}, 16'd1);
    endtask

    // Issue op to f7, then hold an FPU op to f8 in ID; grant withheld for hold WB cycles.
    task automatic do_b2b(input int hold, input int exp_stalls, input string tag);
        int stalls = 0;
        int wbn    = 0;
        bit issued = 0;
        clear_inputs();
        valid_id = 1; fpu_id = 1; Z_id = 4'd7; RW_id = 3'b100; fpu_wb_gnt = 0;
        #1;
        check({tag, "_issue1"}, {15'd0, fpu_issue}, 16'd1);
        tick();
        Z_id = 4'd8;
        for (int c = 0; c < 40 && !issued; c++) begin
            fpu_wb_gnt = (wbn >= hold);
            #1;
            if (fpu_issue) issued = 1;
            else begin
                if (stall_id) stalls++;
                if (fpu_wb_req) wbn++;
                tick();
            end
        end
        check({tag, "_issued2"}, {15'd0, issued}, 16'd1);
        check({tag, "_stalls"}, stalls[15:0], exp_stalls[15:0]);
        tick();
        clear_inputs();
        #1;
        check({tag, "_busy2"}, {15'd0, fpu_busy}, 16'd1);
        check({tag, "_wbz2"}, {12'd0, fpu_wb_z}, 16'd8);
        drain();
    endtask

    initial begin
        bit seen;
        clear_inputs();
        fpu_wb_gnt = 0;
        rst_n = 0;
        #12;
        check("rst_busy", {15'd0, fpu_busy}, 16'd0);
        check("rst_wbreq", {15'd0, fpu_wb_req}, 16'd0);
        check("rst_wbz", {12'd0, fpu_wb_z}, 16'd0);
        check("rst_cnt", stall_cnt, 16'd0);
        rst_n = 1;
        tick();

        // Load-use: one stall cycle, then the load leaves EX.
        set_load_use();
        #1;
        check("lu_stall_if", {15'd0, stall_if}, 16'd1);
        check("lu_stall_id", {15'd0, stall_id}, 16'd1);
        check("lu_bubble", {15'd0, bubble_ex}, 16'd1);
        check("lu_flush", {15'd0, flush_id}, 16'd0);
        tick();
        mem_rd_ex = 0;
        #1;
        check("lu_release", {15'd0, stall_id}, 16'd0);
        check("lu_cnt", stall_cnt, 16'd1);
        set_load_use();
        use_y_id = 0;
        #1;
        check("lu_nouse", {15'd0, stall_id}, 16'd0);
        tick();

        // FPU op to f5, grant tied high, reader of f5 stalled for all busy cycles.
        clear_inputs();
        fpu_wb_gnt = 1;
        valid_id = 1; fpu_id = 1; Z_id = 4'd5; RW_id = 3'b100;
        #1;
        check("fpu_issue", {15'd0, fpu_issue}, 16'd1);
        tick();
        fpu_id = 0; src_fp_id = 1; Y_id = 4'd5; use_y_id = 1; Z_id = 4'd6;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fpu_busy_%0d", i), {15'd0, fpu_busy}, 16'd1);
            check($sformatf("fpu_stall_%0d", i), {15'd0, stall_id}, 16'd1);
            check($sformatf("fpu_req_%0d", i), {15'd0, fpu_wb_req}, (i == 3) ? 16'd1 : 16'd0);
            check($sformatf("fpu_wbz_%0d", i), {12'd0, fpu_wb_z}, 16'd5);
            check($sformatf("fpu_noissue_%0d", i), {15'd0, fpu_issue}, 16'd0);
            tick();
        end
        #1;
        check("fpu_done_busy", {15'd0, fpu_busy}, 16'd0);
        check("fpu_done_stall", {15'd0, stall_id}, 16'd0);
        check("fpu_done_wbz", {12'd0, fpu_wb_z}, 16'd0);
        check("fpu_cnt", stall_cnt, 16'd5);

        do_b2b(0, 4, "b2b");
        check("b2b_cnt", stall_cnt, 16'd9);
        do_b2b(5, 9, "b2bhold");
        check("b2bhold_cnt", stall_cnt, 16'd18);

        // Branch wins over load-use and FPU hazard; in-flight op still writes back.
        clear_inputs();
        fpu_wb_gnt = 0;
        valid_id = 1; fpu_id = 1; Z_id = 4'd9; RW_id = 3'b100;
        tick();
        clear_inputs();
        set_load_use();
        fpu_id = 1;
        branch_taken_ex = 1;
        #1;
        check("br_flush", {15'd0, flush_id}, 16'd1);
        check("br_bubble", {15'd0, bubble_ex}, 16'd1);
        check("br_stall_id", {15'd0, stall_id}, 16'd0);
        check("br_stall_if", {15'd0, stall_if}, 16'd0);
        check("br_issue", {15'd0, fpu_issue}, 16'd0);
        tick();
        clear_inputs();
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (fpu_wb_req) seen = 1;
            else tick();
        end
        check("br_wbreq", {15'd0, seen}, 16'd1);
        check("br_wbz", {12'd0, fpu_wb_z}, 16'd9);
        check("br_cnt", stall_cnt, 16'd18);
        drain();

        // Async reset while in WB.
        clear_inputs();
        fpu_wb_gnt = 0;
        valid_id = 1; fpu_id = 1; Z_id = 4'd10; RW_id = 3'b100;
        tick();
        clear_inputs();
        tick(); tick(); tick();
        check("rst_pre_req", {15'd0, fpu_wb_req}, 16'd1);
        #2 rst_n = 0;
        #1;
        check("arst_busy", {15'd0, fpu_busy}, 16'd0);
        check("arst_req", {15'd0, fpu_wb_req}, 16'd0);
        check("arst_wbz", {12'd0, fpu_wb_z}, 16'd0);
        check("arst_cnt", stall_cnt, 16'd0);
        #3 rst_n = 1;
        tick(); tick(); tick(); tick();
        check("arst_noreq", {15'd0, fpu_wb_req}, 16'd0);

        // Saturation of the stall counter.
        set_load_use();
        for (int c = 0; c < 70000; c++) tick();
        check("sat_cnt", stall_cnt, 16'hFFFF);
        check("sat_stall", {15'd0, stall_id}, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
